crc_qsys_onchip_memory_pipelined: RTL
=====================================

# crc_qsys_onchip_memory_pipelined

Parametrised on-chip RAM exposed as an Avalon-MM slave in the CRC Qsys system, replacing the fixed 32-bit × 1024 single-port memory for new instances. It adds:
- configurable data width, depth and read latency;
- pipelined reads with `readdatavalid`;
- a `waitrequest`-based stall;
- a hardware clear engine that zero-fills the array after reset or on command.

It serves as scratch/buffer memory for the CRC datapath and the processor.

## Interface

Parameters:
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 10: word-address width.
- `DEPTH`, 2**`ADDR_WIDTH`: number of words, 2 ≤ `DEPTH` ≤ 2**`ADDR_WIDTH`.
- `READ_LATENCY`, 2: cycles from read acceptance to `readdatavalid`; legal values 1 or 2.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill the array automatically after reset release.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in `ADDR_WIDTH`: word address.
- `byteenable` in `DATA_WIDTH`/8: write lane enables.
- `chipselect` in 1: slave select.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in `DATA_WIDTH`: write data.
- `readdata` out `DATA_WIDTH`: read data, valid only with `readdatavalid`.
- `readdatavalid` out 1: one-cycle strobe per accepted read.
- `waitrequest` out 1: when high, no request is accepted.
- `clear` in 1: single-cycle pulse that starts a zero-fill.
- `clear_busy` out 1: high while the zero-fill runs.

## Operation

Accept condition:
- A request is accepted on a rising edge when `chipselect` & (`read` | `write`) & ~`waitrequest`.
- If `read` and `write` are both high, only the write is performed; no `readdatavalid` is produced.

Writes:
- Each accepted write updates only the lanes whose `byteenable` bit is 1.
- A write with `byteenable`=0 is accepted and changes nothing.
- An address ≥ `DEPTH` is accepted. Writes to such an address are dropped; reads return 0.

Reads:
- Fully pipelined: one accepted read per cycle is sustained.
- Each accepted read yields exactly one `readdatavalid`, in request order, with no bubbles inserted.

Clear FSM, two states:
- IDLE → CLEAR when `clear` is sampled high. Also enters CLEAR on reset release if `CLEAR_ON_RESET`=1.
- In CLEAR, a counter walks 0..`DEPTH`-1 and writes all-zero words, one per cycle.
- CLEAR → IDLE after the write to address `DEPTH`-1.
- `clear` sampled while in CLEAR is ignored; the fill does not restart.

Interaction between clear and pending traffic:
- `waitrequest` = (state == CLEAR). Masters hold their request until it is accepted.
- Reads accepted before CLEAR was entered complete normally. They return pre-clear data and their `readdatavalid` may fall inside CLEAR.
- A request presented in the same cycle that `clear` is sampled is accepted and completes before the first zero-write.

Reset behaviour:
- Memory contents are not touched by `reset_n` directly; they change only through writes or the clear engine.
- Asserting `reset_n` mid-clear aborts the fill and zeroes the counter. On release, the fill restarts from address 0 if `CLEAR_ON_RESET`=1; otherwise contents are partially cleared and the FSM is IDLE.

## Timing

Reset values:
- `readdata` = 0.
- `readdatavalid` = 0.
- `waitrequest` = `clear_busy` = `CLEAR_ON_RESET`.
- FSM state = CLEAR if `CLEAR_ON_RESET`, else IDLE.
- Read pipeline valid bits = 0.

Read latency:
- A read accepted at edge N has `readdatavalid` high and `readdata` valid during the cycle following edge N+`READ_LATENCY`-1.
- Latency 1: the RAM output drives `readdata` directly.
- Latency 2: the RAM output passes through an extra output register.
- Outside `readdatavalid`, `readdata` holds its last value.

Read-after-write:
- A write at edge N followed by a read of the same address at edge N+1 returns the new data.

Clear timing:
- `clear` sampled at edge E0 → `clear_busy`/`waitrequest` rise after E0.
- Zero-writes occur at edges E1..E`DEPTH`.
- `clear_busy`/`waitrequest` fall after E`DEPTH`, giving exactly `DEPTH` busy cycles.
- First acceptable request is at edge E`DEPTH`+1.
- After reset release with `CLEAR_ON_RESET`=1: zero-writes occur at the first `DEPTH` edges, and the first request is accepted at edge `DEPTH`+1.

Counter:
- `ADDR_WIDTH` bits.
- Terminal compare against `DEPTH`-1, so no wrap-around past `DEPTH`.

## Test plan

Each scenario uses DATA_WIDTH=32, ADDR_WIDTH=4 (DEPTH=16), READ_LATENCY=2.

- Reset release with CLEAR_ON_RESET=1 → `waitrequest` high for exactly 16 cycles, then low; reads of all 16 addresses return 0x00000000.
- Write 0xDEADBEEF to address 3 with byteenable=4'b0101, after a prior full write of 0x11223344 → read of address 3 returns 0x11AD33EF, with `readdatavalid` 2 cycles after acceptance.
- Back-to-back reads of addresses 0..7, one per cycle → 8 consecutive `readdatavalid` pulses, in order, starting 2 cycles after the first acceptance.
- Two reads issued, then `clear` pulsed in the next cycle → both `readdatavalid` pulses deliver pre-clear data; a write held against `waitrequest` is accepted only after 16 busy cycles.
- `reset_n` asserted at clear counter value 7 → outputs reach reset values immediately; after release the fill restarts at address 0 and lasts 16 cycles.
- READ_LATENCY=1 build: a read accepted at edge N → `readdatavalid` is high in the cycle after edge N; a write at edge N plus a read of the same address at edge N+1 returns the new value.

Source files
------------

// File: rtl/crc_qsys_onchip_memory_pipelined.sv
// crc_qsys_onchip_memory_pipelined
// Parametrised single-port on-chip RAM behind an Avalon-MM slave port.
// Reads are pipelined (latency 1 or 2) and each one returns a readdatavalid strobe.
// A small clear engine zero-fills the whole array, either after reset or when
// `clear` is pulsed. While the fill runs, waitrequest is held high.
module crc_qsys_onchip_memory_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic                    clear,
  output logic                    clear_busy
);

  localparam int                  LANES     = DATA_WIDTH / 8;
  // One extra bit so that DEPTH == 2**ADDR_WIDTH still fits in the range compare.
  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_r;
  logic                    busy_r;
  logic [ADDR_WIDTH-1:0]   clr_cnt_r;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0]   ram_q_r;
  logic                    ram_v_r;
  logic                    accept_s;
  logic                    wr_acc_s;
  logic                    rd_acc_s;
  logic                    in_range_s;

  // Request decode: a write wins over a simultaneous read, and out-of-range addresses are flagged.
  always_comb begin
    accept_s   = 1'b0;
    wr_acc_s   = 1'b0;
    rd_acc_s   = 1'b0;
    in_range_s = ({1'b0, address} < DEPTH_L);
    if (chipselect && (read || write) && !busy_r) begin
      accept_s = 1'b1;
      wr_acc_s = write;
      rd_acc_s = read && !write;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Clear FSM: walks the counter across every word, then returns to IDLE. Reset aborts the fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      busy_r    <= (CLEAR_ON_RESET != 0);
      clr_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (clear) begin
            state_r   <= CLEAR;
            busy_r    <= 1'b1;
            clr_cnt_r <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt_r == LAST_ADDR) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            clr_cnt_r <= '0;
          end else begin
            clr_cnt_r <= clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          clr_cnt_r <= '0;
        end
      endcase
    end
  end

  // Array write port. The clear engine and bus writes are exclusive, because waitrequest blocks the bus during CLEAR.
  // While reset is held, no write reaches the array.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_r == CLEAR) begin
        mem[clr_cnt_r] <= '0;
      end else if (wr_acc_s && in_range_s) begin
        for (int i = 0; i < LANES; i++) begin
          if (byteenable[i]) begin
            mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
          end
        end
      end
    end
  end

  // First read stage: the RAM output register is loaded only on an accepted read, so it holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_q_r <= '0;
      ram_v_r <= 1'b0;
    end else begin
      ram_v_r <= rd_acc_s;
      if (rd_acc_s) begin
        ram_q_r <= in_range_s ? mem[address] : '0;
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign readdata      = ram_q_r;
      assign readdatavalid = ram_v_r;
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] out_q_r;
      logic                  out_v_r;

      // Extra output register stage. The data is only updated when a valid word moves through.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_q_r <= '0;
          out_v_r <= 1'b0;
        end else begin
          out_v_r <= ram_v_r;
          if (ram_v_r) begin
            out_q_r <= ram_q_r;
          end
        end
      end

      assign readdata      = out_q_r;
      assign readdatavalid = out_v_r;
    end
  endgenerate

  assign waitrequest = busy_r;
  assign clear_busy  = busy_r;

endmodule
